// File: rtl/receiver_if.sv
// Receiver bus interface: groups the upstream four-phase handshake
// (Request/rcvDataIn/Ack) and the downstream show-ahead FIFO port
// (Read/Valid/rcvDataOut/Count/Full).
// The slave modport is the receiver's view; the master modport is the
// view of whatever drives the sender and consumer sides.
interface receiver_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int DATA_W = 16;

    logic              Request;
    logic [DATA_W-1:0] rcvDataIn;
    logic              Ack;
    logic              Read;
    logic              Valid;
    logic [DATA_W-1:0] rcvDataOut;
    logic [CNT_W-1:0]  Count;
    logic              Full;

    modport slave (
        input  Request,
        input  rcvDataIn,
        input  Read,
        output Ack,
        output Valid,
        output rcvDataOut,
        output Count,
        output Full
    );

    modport master (
        output Request,
        output rcvDataIn,
        output Read,
        input  Ack,
        input  Valid,
        input  rcvDataOut,
        input  Count,
        input  Full
    );
endinterface

// File: rtl/receiver.sv
// Four-phase handshake receiver feeding a show-ahead FIFO.
// An IDLE/ACK/WAIT_LOW state machine accepts one word per Request
// assertion and acknowledges it with a single-cycle registered Ack.
// Accepted words are queued in a DEPTH-word FIFO (power of two, 2..16)
// whose head is always visible on rcvDataOut.
// Optional feature: define RCV_WORDCNT_EN to add the 16-bit WordCount
// output counting pushes since reset (wraps at 16'hFFFF).
module receiver #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        Reset,
    receiver_if.slave   bus
`ifdef RCV_WORDCNT_EN
    ,
    output logic [15:0] WordCount
`endif
);

    localparam int DATA_W = 16;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t             state_q;
    logic               ack_q;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               full;
    logic               not_empty;
    logic               push;
    logic               pop;

    // Fullness is judged on the count held before the edge, so a Read in
    // the same cycle cannot open room for a push while Full is high.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign not_empty = (count_q != '0);
    assign push      = (state_q == IDLE) && bus.Request && !full;
    assign pop       = bus.Read && not_empty;

    // Handshake sequencer: accept in IDLE, pulse Ack for one cycle, then
    // wait for the sender to drop Request so one assertion gives one push.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (push) begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        ack_q   <= 1'b0;
                    end
                end
                ACK: begin
                    state_q <= WAIT_LOW;
                    ack_q   <= 1'b0;
                end
                WAIT_LOW: begin
                    ack_q <= 1'b0;
                    if (!bus.Request) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT_LOW;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    // Next pointer/occupancy values; pointers wrap naturally at DEPTH
    // because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO control state; reset discards all queued words.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.rcvDataIn;
        end
    end

    assign bus.Ack        = ack_q;
    assign bus.Valid      = not_empty;
    assign bus.rcvDataOut = mem_q[rd_ptr_q];
    assign bus.Count      = count_q;
    assign bus.Full       = full;

`ifdef RCV_WORDCNT_EN
    logic [15:0] word_cnt_q, word_cnt_d;

    // Push tally; wraps from 16'hFFFF to zero.
    always_comb begin
        word_cnt_d = word_cnt_q;
        if (push) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

    // Push tally register, cleared by reset.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign WordCount = word_cnt_q;
`endif

    // Occupancy must stay within 0..DEPTH and Ack only appears in ACK.
    always_ff @(posedge clk) begin
        if (Reset) begin
            assert (count_q <= CNT_W'(DEPTH))
                else $error("receiver: count above DEPTH");
            assert (!ack_q || (state_q == ACK))
                else $error("receiver: Ack outside ACK state");
        end
    end

endmodule
